// File: rtl/echo_pkg.sv
// Shared definitions for the feedback echo stage: FSM encoding and the saturating narrow helper.
package echo_pkg;

    localparam int unsigned SatWidth = 16;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StRead,
        StMix,
        StWrite
    } echo_state_e;

    // A 17-bit sum overflowed exactly when its top two bits disagree.
    function automatic logic [SatWidth-1:0] sat16(input logic [SatWidth:0] v);
        if (v[SatWidth] != v[SatWidth-1]) begin
            return v[SatWidth] ? 16'h8000 : 16'h7FFF;
        end
        return v[SatWidth-1:0];
    endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous delay-line RAM; read data registered, contents not reset.
module echo_ram #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem [2**AddrWidth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_echo.sv
// Feedback echo: mixes an attenuated delayed sample back into the stream and stores the mix,
// so repeats decay geometrically. Clears the delay line after reset.
module sample_echo
    import echo_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DECAY_SHIFT  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [ADDR_WIDTH-1:0]   delay_len,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    in_ready,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    out_valid,
    output logic                    overrun
);

    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    echo_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   d_len_q, d_len_d;
    logic                    en_q, en_d;
    logic [SAMPLE_WIDTH-1:0] x_q, x_d;
    logic [SAMPLE_WIDTH-1:0] y_q, y_d;
    logic [SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic                    ram_en, ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [SAMPLE_WIDTH-1:0] ram_wdata, ram_rdata;
    logic [SAMPLE_WIDTH-1:0] decayed;
    logic [SAMPLE_WIDTH:0]   mix_sum;

    echo_ram #(
        .DataWidth(SAMPLE_WIDTH),
        .AddrWidth(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign decayed = $signed(ram_rdata) >>> DECAY_SHIFT;
    assign mix_sum = {x_q[SAMPLE_WIDTH-1], x_q} + {decayed[SAMPLE_WIDTH-1], decayed};

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        d_len_d      = d_len_q;
        en_d         = en_q;
        x_d          = x_q;
        y_d          = y_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = wr_ptr_q;
        ram_wdata    = y_q;

        unique case (state_q)
            StClear: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + AddrOne;
                if (clr_cnt_q == '1) begin
                    state_d = StIdle;
                end
                if (in_ready) begin
                    sample_out_d = sample_in;
                    out_valid_d  = 1'b1;
                end
            end
            StIdle: begin
                if (in_ready) begin
                    x_d      = sample_in;
                    d_len_d  = delay_len;
                    en_d     = enable;
                    ram_en   = 1'b1;
                    ram_addr = wr_ptr_q - delay_len;
                    state_d  = StRead;
                end
            end
            StRead: begin
                state_d = StMix;
            end
            StMix: begin
                // Bypassed samples still enter the delay line so enabling later has no stale burst.
                if (!en_q || d_len_q == '0) begin
                    y_d = x_q;
                end else begin
                    y_d = sat16(mix_sum);
                end
                state_d = StWrite;
            end
            StWrite: begin
                ram_en       = 1'b1;
                ram_we       = 1'b1;
                wr_ptr_d     = wr_ptr_q + AddrOne;
                sample_out_d = y_q;
                out_valid_d  = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase

        if (in_ready && (state_q == StRead || state_q == StMix || state_q == StWrite)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            d_len_q      <= '0;
            en_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            d_len_q      <= d_len_d;
            en_q         <= en_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_echo.sv
// Directed bench for sample_echo with a 16-deep delay line.
module tb_sample_echo;

    localparam int unsigned SW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned DS = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          in_ready = 1'b0;
    logic [AW-1:0] delay_len = '0;
    logic [SW-1:0] sample_in = '0;
    logic [SW-1:0] sample_out;
    logic          out_valid;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;

    sample_echo #(
        .SAMPLE_WIDTH(SW),
        .ADDR_WIDTH  (AW),
        .DECAY_SHIFT (DS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .delay_len (delay_len),
        .sample_in (sample_in),
        .in_ready  (in_ready),
        .sample_out(sample_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        in_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (16) step();
    endtask

    // One strobe; waits (bounded) for out_valid, checks latency, data and pulse width.
    task automatic send(input logic [SW-1:0] x, input logic en, input logic [AW-1:0] dly,
                        input logic [SW-1:0] exp, input int exp_lat, input string tag);
        int lat;
        sample_in = x;
        enable    = en;
        delay_len = dly;
        in_ready  = 1'b1;
        step();
        in_ready = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        check_eq({tag, " lat"}, lat, exp_lat);
        check_eq({tag, " data"}, sample_out, exp);
        step();
        check_eq({tag, " pulse"}, out_valid, 0);
    endtask

    logic [SW-1:0] t2_exp [10];
    logic signed [SW-1:0] mbuf [16];
    logic signed [SW-1:0] mx, md;
    logic [SW-1:0] v;
    int wp, s, lat, pulses;

    initial begin
        t2_exp = '{16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000,
                   16'h1000, 16'h0000, 16'h0000, 16'h0800};

        // Reset values and CLEAR passthrough
        step();
        check_eq("rst sample_out", sample_out, 0);
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst overrun", overrun, 0);
        reset = 1'b0;
        send(16'h1234, 1'b0, '0, 16'h1234, 1, "clear_pass");
        repeat (13) step();
        send(16'h5678, 1'b0, '0, 16'h5678, 1, "clear_last");
        send(16'h2222, 1'b0, '0, 16'h2222, 4, "idle_first");
        check_eq("clear overrun", overrun, 0);

        // Impulse decay with delay 3
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send((k == 0) ? 16'h4000 : 16'h0000, 1'b1, 4'd3, t2_exp[k], 4, "impulse");
            repeat (5) step();
        end

        // Saturation both directions
        do_reset();
        send(16'h7000, 1'b0, 4'd1, 16'h7000, 4, "sat_fill_pos");
        send(16'h6000, 1'b1, 4'd1, 16'h7FFF, 4, "sat_pos");
        send(16'h9000, 1'b0, 4'd1, 16'h9000, 4, "sat_fill_neg");
        send(16'hA000, 1'b1, 4'd1, 16'h8000, 4, "sat_neg");

        // Back-to-back strobes: second is dropped and overrun sticks
        do_reset();
        check_eq("b2b overrun pre", overrun, 0);
        sample_in = 16'h0100;
        enable    = 1'b0;
        delay_len = '0;
        in_ready  = 1'b1;
        step();
        sample_in = 16'h0200;
        step();
        in_ready = 1'b0;
        lat      = 2;
        while (out_valid !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        check_eq("b2b lat", lat, 4);
        check_eq("b2b data", sample_out, 16'h0100);
        pulses = 0;
        repeat (8) begin
            step();
            if (out_valid === 1'b1) pulses++;
        end
        check_eq("b2b extra pulses", pulses, 0);
        check_eq("b2b overrun", overrun, 1);
        send(16'h0300, 1'b0, '0, 16'h0300, 4, "b2b after");
        check_eq("b2b overrun sticky", overrun, 1);
        do_reset();
        check_eq("overrun cleared", overrun, 0);

        // Bypass for 20 samples, then enable with delay 5
        for (int i = 0; i < 20; i++) begin
            v = 16'(i * 16'h0123);
            send(v, i[0], i[0] ? 4'd0 : 4'd7, v, 4, "bypass");
        end
        send(16'h0040, 1'b1, 4'd5, 16'h08C6, 4, "first_echo");

        // Wrap with delay 15 against a reference delay line
        do_reset();
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
        wp = 0;
        for (int i = 0; i < 40; i++) begin
            mx = 16'(i * 2833 - 20000);
            md = mbuf[(wp - 15) & 15];
            s  = int'(mx) + int'(md >>> 1);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            mbuf[wp] = 16'(s);
            send(mx, 1'b1, 4'd15, 16'(s), 4, "wrap");
            wp = (wp + 1) & 15;
        end

        // Reset while in MIX discards the sample
        sample_in = 16'h1111;
        enable    = 1'b1;
        delay_len = 4'd15;
        in_ready  = 1'b1;
        step();
        in_ready = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_eq("mid rst out_valid", out_valid, 0);
        check_eq("mid rst sample_out", sample_out, 0);
        check_eq("mid rst overrun", overrun, 0);
        step();
        reset  = 1'b0;
        pulses = 0;
        repeat (4) begin
            step();
            if (out_valid === 1'b1) pulses++;
        end
        check_eq("mid rst no valid", pulses, 0);
        send(16'h0ABC, 1'b1, 4'd3, 16'h0ABC, 1, "mid rst clear");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
